// File: rtl/bus_to_st.sv
// bus_to_st: serializes wide bus words into a packetized Avalon-ST symbol
// stream of fixed-size turbo packets, with sop/eop framing.
//
// Ports:
//   clk_400   : single clock for all logic
//   rst_n     : asynchronous active-low reset
//   bus_data  : bus word; payload in the top ST_PER_BUS bits
//   bus_en    : write strobe, honored only while bus_ready=1
//   bus_ready : 2-entry word buffer is not full
//   st_ready  : sink ready, ready latency 0
//   st_data   : output symbol
//   st_valid  : symbol valid
//   st_sop    : first symbol of a turbo packet
//   st_eop    : last symbol of a turbo packet
//   st_error  : always 0
module bus_to_st #(
    parameter int BUS                   = 534,
    parameter int ST_PER_BUS            = 512,
    parameter int NUM_ST_PER_BUS        = 42,
    parameter int ST_PER_TURBO_PKT      = 1028,
    parameter int NUM_BUS_PER_TURBO_PKT = 25,
    parameter int ST                    = 12
) (
    input  logic          clk_400,
    input  logic          rst_n,
    input  logic [BUS-1:0] bus_data,
    input  logic          bus_en,
    output logic          bus_ready,
    input  logic          st_ready,
    output logic [ST-1:0] st_data,
    output logic          st_valid,
    output logic          st_sop,
    output logic          st_eop,
    output logic          st_error
);

    localparam int SYM_W   = $clog2(NUM_ST_PER_BUS);
    localparam int BIDX_W  = $clog2(NUM_BUS_PER_TURBO_PKT);
    localparam int PKT_W   = $clog2(ST_PER_TURBO_PKT);
    localparam int PAY_LSB = BUS - ST_PER_BUS;
    localparam int LAST_USED = ST_PER_TURBO_PKT
                             - (NUM_BUS_PER_TURBO_PKT - 1) * NUM_ST_PER_BUS;

    localparam logic [SYM_W-1:0]  SYM_FULL_END = SYM_W'(NUM_ST_PER_BUS - 1);
    localparam logic [SYM_W-1:0]  SYM_LAST_END = SYM_W'(LAST_USED - 1);
    localparam logic [BIDX_W-1:0] BIDX_END     = BIDX_W'(NUM_BUS_PER_TURBO_PKT - 1);
    localparam logic [PKT_W-1:0]  PKT_END      = PKT_W'(ST_PER_TURBO_PKT - 1);

    // word buffer
    logic [BUS-1:0] mem_q [2];
    logic           wr_ptr_q, wr_ptr_d;
    logic           rd_ptr_q, rd_ptr_d;
    logic [1:0]     cnt_q, cnt_d;

    // position counters
    logic [SYM_W-1:0]  sym_idx_q, sym_idx_d;
    logic [BIDX_W-1:0] bus_idx_q, bus_idx_d;
    logic [PKT_W-1:0]  pkt_sym_q, pkt_sym_d;

    // output register
    logic [ST-1:0] data_q, data_d;
    logic          valid_q, valid_d;
    logic          sop_q, sop_d;
    logic          eop_q, eop_d;

    logic [BUS-1:0]   head;
    logic [ST-1:0]    syms [NUM_ST_PER_BUS];
    logic [ST-1:0]    head_sym;
    logic [SYM_W-1:0] sym_end;
    logic             empty, full;
    logic             load_en, do_load, last_sym;
    logic             push, pop;

    assign head = mem_q[rd_ptr_q];

    always_comb begin
        for (int k = 0; k < NUM_ST_PER_BUS; k++) begin
            syms[k] = head[PAY_LSB + ST*k +: ST];
        end
    end

    assign head_sym = syms[sym_idx_q];

    assign empty    = (cnt_q == 2'd0);
    assign full     = (cnt_q == 2'd2);
    assign load_en  = !valid_q || st_ready;
    assign do_load  = load_en && !empty;
    // the packet's final word only carries the tail of the packet
    assign sym_end  = (bus_idx_q == BIDX_END) ? SYM_LAST_END : SYM_FULL_END;
    assign last_sym = (sym_idx_q == sym_end);
    assign push     = bus_en && !full;
    assign pop      = do_load && last_sym;

    assign bus_ready = !full;
    assign st_data   = data_q;
    assign st_valid  = valid_q;
    assign st_sop    = sop_q;
    assign st_eop    = eop_q;
    assign st_error  = 1'b0;

    always_comb begin
        sym_idx_d = sym_idx_q;
        bus_idx_d = bus_idx_q;
        pkt_sym_d = pkt_sym_q;
        data_d    = data_q;
        valid_d   = valid_q;
        sop_d     = sop_q;
        eop_d     = eop_q;
        wr_ptr_d  = push ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d  = pop  ? ~rd_ptr_q : rd_ptr_q;
        cnt_d     = cnt_q;

        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase

        if (do_load) begin
            data_d    = head_sym;
            valid_d   = 1'b1;
            sop_d     = (pkt_sym_q == '0);
            eop_d     = (pkt_sym_q == PKT_END);
            pkt_sym_d = (pkt_sym_q == PKT_END) ? '0 : pkt_sym_q + 1'b1;
            if (last_sym) begin
                sym_idx_d = '0;
                bus_idx_d = (bus_idx_q == BIDX_END) ? '0 : bus_idx_q + 1'b1;
            end else begin
                sym_idx_d = sym_idx_q + 1'b1;
            end
        end else if (load_en) begin
            // symbol consumed with nothing to replace it
            valid_d = 1'b0;
            sop_d   = 1'b0;
            eop_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_400 or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0]  <= '0;
            mem_q[1]  <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            cnt_q     <= '0;
            sym_idx_q <= '0;
            bus_idx_q <= '0;
            pkt_sym_q <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            sop_q     <= 1'b0;
            eop_q     <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= bus_data;
            end
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            sym_idx_q <= sym_idx_d;
            bus_idx_q <= bus_idx_d;
            pkt_sym_q <= pkt_sym_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            sop_q     <= sop_d;
            eop_q     <= eop_d;
        end
    end

endmodule

// File: tb/tb_bus_to_st.sv
// tb_bus_to_st: directed stimulus with a queue scoreboard and an
// independent output monitor for bus_to_st.
module tb_bus_to_st;

    logic         clk_400 = 1'b0;
    logic         rst_n;
    logic [533:0] bus_data;
    logic         bus_en;
    logic         bus_ready;
    logic         st_ready;
    logic [11:0]  st_data;
    logic         st_valid;
    logic         st_sop;
    logic         st_eop;
    logic         st_error;

    typedef struct packed {
        logic [11:0] d;
        logic        sop;
        logic        eop;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    logic tog = 1'b0;
    logic rdy_val = 1'b1;

    bus_to_st dut (
        .clk_400  (clk_400),
        .rst_n    (rst_n),
        .bus_data (bus_data),
        .bus_en   (bus_en),
        .bus_ready(bus_ready),
        .st_ready (st_ready),
        .st_data  (st_data),
        .st_valid (st_valid),
        .st_sop   (st_sop),
        .st_eop   (st_eop),
        .st_error (st_error)
    );

    always #5 clk_400 = ~clk_400;

    // sink ready changes shortly after each rising edge
    initial st_ready = 1'b1;
    always @(posedge clk_400) begin
        #2;
        if (tog) st_ready = ~st_ready;
        else     st_ready = rdy_val;
    end

    // word with symbol k = start+k; ignored bits filled with ones
    function automatic logic [533:0] mk(input int start);
        logic [533:0] w;
        logic [11:0]  s;
        w = '1;
        for (int k = 0; k < 42; k++) begin
            s = 12'((start + k) & 12'hFFF);
            w[22 + 12*k +: 12] = s;
        end
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // monitor: scoreboard compare on handshake, stability under backpressure
    logic        hold_chk = 1'b0;
    logic [11:0] h_d;
    logic        h_s, h_e;
    exp_t        e;

    always @(negedge clk_400) begin
        if (!rst_n) begin
            hold_chk = 1'b0;
        end else begin
            if (hold_chk) begin
                checks++;
                if (!(st_valid && st_data == h_d && st_sop == h_s
                      && st_eop == h_e)) begin
                    failures++;
                    $display("FAIL hold actual=%0b/%0h/%0b/%0b required=1/%0h/%0b/%0b",
                             st_valid, st_data, st_sop, st_eop, h_d, h_s, h_e);
                end
            end
            hold_chk = st_valid && !st_ready;
            h_d = st_data;
            h_s = st_sop;
            h_e = st_eop;
            if (st_valid && st_ready) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_symbol actual=%0h required=none",
                             st_data);
                end else begin
                    e = q.pop_front();
                    if (st_data !== e.d || st_sop !== e.sop
                        || st_eop !== e.eop) begin
                        failures++;
                        $display("FAIL symbol actual=%0h/%0b/%0b required=%0h/%0b/%0b",
                                 st_data, st_sop, st_eop, e.d, e.sop, e.eop);
                    end
                end
                checks++;
                if (st_error !== 1'b0) begin
                    failures++;
                    $display("FAIL st_error actual=%0b required=0", st_error);
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk_400);
        rst_n  = 1'b0;
        bus_en = 1'b0;
        q.delete();
        repeat (2) @(negedge clk_400);
        rst_n = 1'b1;
    endtask

    task automatic write_word(input logic [533:0] w);
        int n = 0;
        @(negedge clk_400);
        while (!bus_ready && n < 3000) begin
            @(negedge clk_400);
            n++;
        end
        if (!bus_ready) begin
            checks++;
            failures++;
            $display("FAIL write_timeout actual=0 required=1");
        end
        bus_data = w;
        bus_en   = 1'b1;
        @(negedge clk_400);
        bus_en   = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge clk_400);
            n++;
        end
        chk(name, q.size(), 0);
    endtask

    task automatic push_range(input int start, input int n, input int eop_at);
        exp_t x;
        for (int i = 0; i < n; i++) begin
            x.d   = 12'((start + i) & 12'hFFF);
            x.sop = (i == 0);
            x.eop = (i == eop_at);
            q.push_back(x);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        bus_en   = 1'b0;
        bus_data = '0;

        // reset state
        repeat (2) @(negedge clk_400);
        chk("rst_valid", st_valid, 0);
        chk("rst_sop", st_sop, 0);
        chk("rst_eop", st_eop, 0);
        chk("rst_data", st_data, 0);
        chk("rst_bus_ready", bus_ready, 1);
        chk("rst_error", st_error, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk_400);
        chk("idle_valid", st_valid, 0);
        chk("idle_sop", st_sop, 0);

        // single word, values 1..42, with latency check
        push_range(1, 42, -1);
        bus_data = mk(1);
        bus_en   = 1'b1;
        @(negedge clk_400);
        bus_en   = 1'b0;
        chk("lat_edge_n", st_valid, 0);
        @(negedge clk_400);
        chk("lat_edge_n1_valid", st_valid, 1);
        chk("lat_edge_n1_data", st_data, 1);
        drain("single_drain", 200);
        repeat (3) @(negedge clk_400);
        chk("single_idle", st_valid, 0);

        // full packet plus first word of the next packet
        do_reset();
        push_range(0, 1028, 1027);
        push_range(12'hA00, 42, -1);
        for (int w = 0; w < 25; w++) begin
            write_word(mk(42*w));
            repeat (40) @(negedge clk_400);
        end
        write_word(mk(12'hA00));
        drain("packet_drain", 500);

        // backpressure: ready toggles every cycle
        do_reset();
        tog = 1'b1;
        push_range(0, 1028, 1027);
        for (int w = 0; w < 25; w++) write_word(mk(42*w));
        drain("bp_drain", 5000);
        tog = 1'b0;
        rdy_val = 1'b1;

        // overflow: three back-to-back writes with sink stalled
        do_reset();
        rdy_val = 1'b0;
        repeat (2) @(negedge clk_400);
        push_range(12'h100, 42, -1);
        push_range(12'h200, 42, -1);
        q[42].sop = 1'b0;
        bus_data = mk(12'h100);
        bus_en   = 1'b1;
        @(negedge clk_400);
        chk("ovf_ready_after1", bus_ready, 1);
        bus_data = mk(12'h200);
        @(negedge clk_400);
        chk("ovf_ready_after2", bus_ready, 0);
        bus_data = mk(12'h300);
        @(negedge clk_400);
        bus_en = 1'b0;
        chk("ovf_ready_after3", bus_ready, 0);
        chk("ovf_head_valid", st_valid, 1);
        chk("ovf_head_data", st_data, 12'h100);
        rdy_val = 1'b1;
        drain("ovf_drain", 300);
        repeat (5) @(negedge clk_400);
        chk("ovf_idle", st_valid, 0);
        chk("ovf_ready_final", bus_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
